fifo_wr_arbiter: RTL

- Round-robin write-port arbiter that shares one FIFO write port among NUM_REQ requesters.
- Grants a requester a burst of up to MAX_BURST beats, then rotates to the next requester.
- Drives the FIFO wr/data_in pins and obeys the FIFO full flag.
- Sits between the requester blocks and the fifo write side. The FIFO write clock is tied to clk.

---
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; bursts of up to MAX_BURST beats, 1 idle cycle per grant.
// fifo_full stalls the owner without losing the grant; FIFO_WR_ARB_STATS_EN adds per-requester beat counters.
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         gnt,
   input  logic                       fifo_full,
   output logic                       fifo_wr,
   output logic [DATA_W-1:0]          fifo_data,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] owner,
   output logic [NUM_REQ*16-1:0]      stat_cnt
);

   localparam int OW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST) + 1;

   typedef enum logic {IDLE, BURST} state_t;

   state_t            state, state_nxt;
   logic [OW-1:0]     owner_nxt;
   logic [BW-1:0]     beat_cnt, beat_nxt;
   logic [DATA_W-1:0] req_slice [NUM_REQ];
   logic              own_req;
   logic              wr_ok;
   logic              pick_vld;
   logic [OW-1:0]     pick_idx;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_slice[gi] = req_data[gi*DATA_W +: DATA_W];
   end

   assign own_req = req[owner];
   // Reset gates the write so nothing lands in the FIFO during the reset cycle.
   assign wr_ok   = (state == BURST) && own_req && !fifo_full && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         owner    <= OW'(NUM_REQ - 1);
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         beat_cnt <= beat_nxt;
      end
   end

   always_comb begin
      pick_vld = 1'b0;
      pick_idx = owner;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!pick_vld && req[(int'(owner) + i) % NUM_REQ]) begin
            pick_vld = 1'b1;
            pick_idx = OW'((int'(owner) + i) % NUM_REQ);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      beat_nxt  = beat_cnt;
      case (state)
         IDLE: begin
            if (pick_vld && !fifo_full) begin
               state_nxt = BURST;
               owner_nxt = pick_idx;
               beat_nxt  = '0;
            end
         end
         BURST: begin
            if (!own_req) begin
               state_nxt = IDLE;
            end else if (wr_ok) begin
               if (beat_cnt == BW'(MAX_BURST - 1))
                  state_nxt = IDLE;
               else
                  beat_nxt = beat_cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == BURST);
      fifo_wr   = wr_ok;
      gnt       = '0;
      fifo_data = '0;
      if (wr_ok) begin
         gnt[owner] = 1'b1;
         fifo_data  = req_slice[owner];
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   logic [15:0] stat_q [NUM_REQ];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reset)
            stat_q[i] <= '0;
         else if (gnt[i] && stat_q[i] != 16'hFFFF)
            stat_q[i] <= stat_q[i] + 16'd1;
      end
   end

   for (genvar gs = 0; gs < NUM_REQ; gs++) begin : g_stat
      assign stat_cnt[gs*16 +: 16] = stat_q[gs];
   end
`else
   assign stat_cnt = '0;
`endif

endmodule
